// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman bit packer.
// Holds the table/stream geometry, the packer state type and mask_to_len,
// which turns a code mask into a code length and a legality flag.
package huffman_pkg;

  localparam int SYM_NUM = 6;
  localparam int CODE_W  = 8;
  localparam int OUT_W   = 8;
  localparam int ACC_W   = CODE_W + OUT_W;
  localparam int CNT_W   = 16;
  localparam int LEN_W   = $clog2(CODE_W + 1);
  localparam int LVL_W   = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // Returns {legal, len}. A legal mask is a non-empty run of ones starting at
  // bit 0. Any other mask gives {0, 0}, so that entry contributes no bits.
  function automatic logic [LEN_W:0] mask_to_len(input logic [CODE_W-1:0] mask);
    logic [LEN_W-1:0] ones;
    logic             contiguous;
    ones = '0;
    for (int i = 0; i < CODE_W; i++) begin
      ones = ones + LEN_W'(mask[i]);
    end
    // mask + 1 clears every bit of a low run of ones and sets no bit inside it.
    contiguous = (mask != '0) && ((mask & (mask + 1'b1)) == '0);
    mask_to_len = contiguous ? {1'b1, ones} : '0;
  endfunction

endpackage

// File: rtl/huffman_len_decode.sv
// Combinational mask decoder for one code-table entry.
// Ports:
//   mask  in  CODE_W  code mask, expected to be 2^len-1
//   len   out LEN_W   code length, 0 when the mask is illegal
//   legal out 1       mask is non-zero and contiguous from bit 0
import huffman_pkg::*;

module huffman_len_decode (
  input  logic [CODE_W-1:0] mask,
  output logic [LEN_W-1:0]  len,
  output logic              legal
);

  always_comb begin
    {legal, len} = mask_to_len(mask);
  end

endmodule

// File: rtl/huffman_bit_packer.sv
// Huffman bit packer: latches a 6-entry code table, packs gray symbols into
// an MSB-first bitstream and emits it as bytes over valid/ready. The last
// partial byte is zero-padded, then done pulses with the frame's bit count.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   code_valid, HC1..HC6,  table load pulse, right-aligned codes,
//   M1..M6                 masks (2^len-1)
//   sym_valid/ready/data/  symbol input handshake, value 1..6,
//   sym_last               last symbol of the frame
//   out_valid/ready/data   packed byte output handshake
//   done, bit_count        end-of-frame pulse and total code bits
//   err                    sticky illegal symbol / illegal mask flag
import huffman_pkg::*;

module huffman_bit_packer (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] HC1,
  input  logic [CODE_W-1:0] HC2,
  input  logic [CODE_W-1:0] HC3,
  input  logic [CODE_W-1:0] HC4,
  input  logic [CODE_W-1:0] HC5,
  input  logic [CODE_W-1:0] HC6,
  input  logic [CODE_W-1:0] M1,
  input  logic [CODE_W-1:0] M2,
  input  logic [CODE_W-1:0] M3,
  input  logic [CODE_W-1:0] M4,
  input  logic [CODE_W-1:0] M5,
  input  logic [CODE_W-1:0] M6,
  input  logic              sym_valid,
  input  logic [CODE_W-1:0] sym_data,
  input  logic              sym_last,
  output logic              sym_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic              err
);

  logic [CODE_W-1:0] hc_in   [SYM_NUM];
  logic [CODE_W-1:0] mask_in [SYM_NUM];
  logic [LEN_W-1:0]  dec_len [SYM_NUM];
  logic [SYM_NUM-1:0] dec_legal;

  assign hc_in[0] = HC1;
  assign hc_in[1] = HC2;
  assign hc_in[2] = HC3;
  assign hc_in[3] = HC4;
  assign hc_in[4] = HC5;
  assign hc_in[5] = HC6;

  assign mask_in[0] = M1;
  assign mask_in[1] = M2;
  assign mask_in[2] = M3;
  assign mask_in[3] = M4;
  assign mask_in[4] = M5;
  assign mask_in[5] = M6;

  for (genvar k = 0; k < SYM_NUM; k++) begin : g_dec
    huffman_len_decode u_dec (
      .mask  (mask_in[k]),
      .len   (dec_len[k]),
      .legal (dec_legal[k])
    );
  end

  logic [CODE_W-1:0] code_tab [SYM_NUM];
  logic [LEN_W-1:0]  len_tab  [SYM_NUM];

  state_t state, state_next;

  logic [ACC_W-1:0] acc;
  logic [LVL_W-1:0] cnt, cnt_next, pop_amt;

  logic              sym_legal;
  logic [LEN_W-1:0]  add_len, eff_len;
  logic [CODE_W-1:0] add_code;
  logic              accept, pop, load;

  always_comb begin
    sym_legal = 1'b0;
    add_len   = '0;
    add_code  = '0;
    for (int k = 0; k < SYM_NUM; k++) begin
      if (sym_data == CODE_W'(k + 1)) begin
        sym_legal = 1'b1;
        add_len   = len_tab[k];
        add_code  = code_tab[k];
      end
    end
  end

  assign sym_ready = (state == ST_RUN) && (cnt <= LVL_W'(ACC_W - CODE_W));
  assign accept    = sym_valid && sym_ready;
  assign load      = (state == ST_IDLE) && code_valid;
  assign eff_len   = (accept && sym_legal) ? add_len : '0;

  // Output side is a function of registers only.
  assign out_valid = (cnt >= LVL_W'(OUT_W)) || ((state == ST_FLUSH) && (cnt != '0));
  assign pop       = out_valid && out_ready;
  assign pop_amt   = (cnt >= LVL_W'(OUT_W)) ? LVL_W'(OUT_W) : cnt;
  assign cnt_next  = cnt + LVL_W'(eff_len) - (pop ? pop_amt : '0);

  // Oldest pending bit is acc[cnt-1]; bits above it are stale and fall off
  // the truncation. A short final byte is left-aligned, zeros below.
  always_comb begin
    if (cnt >= LVL_W'(OUT_W)) begin
      out_data = OUT_W'(acc >> (cnt - LVL_W'(OUT_W)));
    end else begin
      out_data = OUT_W'(acc << (LVL_W'(OUT_W) - cnt));
    end
  end

  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (code_valid) state_next = ST_RUN;
      ST_RUN:   if (accept && sym_last) state_next = ST_FLUSH;
      ST_FLUSH: if (cnt == '0) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      bit_count <= '0;
      err       <= 1'b0;
      for (int k = 0; k < SYM_NUM; k++) begin
        code_tab[k] <= '0;
        len_tab[k]  <= '0;
      end
    end else begin
      cnt <= cnt_next;
      if (load) begin
        // Zero the code of an illegal entry so its zero-length shift adds nothing.
        for (int k = 0; k < SYM_NUM; k++) begin
          code_tab[k] <= dec_legal[k] ? (hc_in[k] & mask_in[k]) : '0;
          len_tab[k]  <= dec_len[k];
        end
        bit_count <= '0;
        if (!(&dec_legal)) err <= 1'b1;
      end
      if (accept) begin
        if (sym_legal) begin
          acc       <= (acc << eff_len) | ACC_W'(add_code);
          bit_count <= bit_count + CNT_W'(eff_len);
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_huffman_bit_packer.sv
module tb_huffman_bit_packer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] HC1 = 8'h01, HC2 = 8'h01, HC3 = 8'h00, HC4 = 8'h03, HC5 = 8'h04, HC6 = 8'h05;
  logic [7:0] M1 = 8'h01, M2 = 8'h03, M3 = 8'h07, M4 = 8'h0F, M5 = 8'h1F, M6 = 8'h1F;
  logic       sym_valid = 1'b0;
  logic [7:0] sym_data = 8'd0;
  logic       sym_last = 1'b0;
  logic       sym_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       done;
  logic [15:0] bit_count;
  logic       err;

  always #5 clk = ~clk;

  huffman_bit_packer dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
    .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_last(sym_last),
    .sym_ready(sym_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .done(done), .bit_count(bit_count), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: symbol codes as bit strings, concatenated and cut into bytes.
  int tab_len [6] = '{1, 2, 3, 4, 5, 5};
  int tab_code[6] = '{1, 1, 0, 3, 4, 5};
  bit model_bits[$];
  int model_total = 0;
  int exp_bytes[$];
  int exp_counts[$];
  int done_cnt = 0;
  int frames_sent = 0;
  bit ready_rand = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_accept(input int s, input bit last);
    if (s >= 1 && s <= 6) begin
      for (int b = tab_len[s-1] - 1; b >= 0; b--) begin
        model_bits.push_back(bit'((tab_code[s-1] >> b) & 1));
      end
      model_total += tab_len[s-1];
    end
    while (model_bits.size() >= 8) begin
      int v = 0;
      for (int i = 0; i < 8; i++) v = (v << 1) | int'(model_bits.pop_front());
      exp_bytes.push_back(v);
    end
    if (last) begin
      if (model_bits.size() > 0) begin
        int v = 0;
        int n = model_bits.size();
        for (int i = 0; i < 8; i++) v = (v << 1) | ((i < n) ? int'(model_bits.pop_front()) : 0);
        exp_bytes.push_back(v);
      end
      exp_counts.push_back(model_total % 65536);
      model_total = 0;
    end
  endtask

  // Monitor / scoreboard
  bit       hold_pend = 1'b0;
  int       held = 0;
  bit       prev_done = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), held);
      end
      if (out_valid && out_ready) begin
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", out_data, $time);
        end else begin
          chk("byte", int'(out_data), exp_bytes.pop_front());
        end
      end
      hold_pend = out_valid && !out_ready;
      held = int'(out_data);
      if (done) begin
        chk("done_single_cycle", int'(prev_done), 0);
        chk("done_bytes_drained", exp_bytes.size(), 0);
        if (exp_counts.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done expected none at %0t", $time);
        end else begin
          chk("bit_count", int'(bit_count), exp_counts.pop_front());
        end
        done_cnt++;
      end
      prev_done = done;
    end
  end

  always @(posedge clk) begin
    if (ready_rand) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic load_table();
    code_valid = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0;
  endtask

  task automatic send_sym(input int s, input bit last);
    bit ok = 1'b0;
    sym_valid = 1'b1;
    sym_data  = 8'(s);
    sym_last  = last;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (sym_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    sym_valid = 1'b0;
    sym_last  = 1'b0;
    if (ok) model_accept(s, last);
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no sym_ready expected accept of sym %0d", s);
    end
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    frames_sent++;
    for (int t = 0; t < 1000 && !seen; t++) begin
      @(negedge clk);
      if (done_cnt >= frames_sent) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got %0d done pulses expected %0d", done_cnt, frames_sent);
      done_cnt = frames_sent;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_n;
    int seq4[7] = '{4, 7, 6, 0, 2, 7, 1};

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sym_ready", int'(sym_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_bit_count", int'(bit_count), 0);
    chk("rst_out_data", int'(out_data), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // IDLE refuses symbols
    sym_valid = 1'b1; sym_data = 8'd1;
    @(negedge clk);
    chk("idle_sym_ready", int'(sym_ready), 0);
    @(posedge clk); #1;
    sym_valid = 1'b0;

    // T1
    load_table();
    @(negedge clk);
    chk("run_sym_ready", int'(sym_ready), 1);
    chk("legal_table_err", int'(err), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send_sym(1, i == 8);
    wait_frame();
    @(negedge clk);
    chk("idle_after_done", int'(sym_ready), 0);
    @(posedge clk); #1;

    // T2
    load_table();
    send_sym(2, 0);
    send_sym(3, 0);
    send_sym(5, 1);
    wait_frame();

    // T3: consumer stalled
    load_table();
    out_ready = 1'b0;
    sym_valid = 1'b1; sym_data = 8'd1; sym_last = 1'b0;
    acc_n = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (sym_ready) begin
        @(posedge clk); #1;
        acc_n++;
        model_accept(1, 0);
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("t3_accepted", acc_n, 9);
    @(negedge clk);
    chk("t3_sym_ready", int'(sym_ready), 0);
    chk("t3_out_valid", int'(out_valid), 1);
    chk("t3_out_data", int'(out_data), 8'hFF);
    @(posedge clk); #1;
    sym_valid = 1'b0;
    out_ready = 1'b1;
    send_sym(1, 1);
    wait_frame();

    // T6: pop and accept in the same cycle at cnt=8
    load_table();
    out_ready = 1'b0;
    send_sym(4, 0);
    send_sym(4, 0);
    @(negedge clk);
    chk("t6_cnt8_valid", int'(out_valid), 1);
    chk("t6_cnt8_ready", int'(sym_ready), 1);
    @(posedge clk); #1;
    sym_valid = 1'b1; sym_data = 8'd6; sym_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t6_accept_ready", int'(sym_ready), 1);
    @(posedge clk); #1;
    sym_valid = 1'b0;
    model_accept(6, 0);
    @(negedge clk);
    chk("t6_cnt5_no_byte", int'(out_valid), 0);
    chk("t6_cnt5_ready", int'(sym_ready), 1);
    @(posedge clk); #1;
    send_sym(1, 1);
    wait_frame();

    // Random frames with random back-pressure
    ready_rand = 1'b1;
    for (int f = 0; f < 25; f++) begin
      int n = int'($urandom_range(1, 12));
      load_table();
      for (int i = 0; i < n; i++) send_sym(int'($urandom_range(1, 6)), i == n - 1);
      wait_frame();
    end
    ready_rand = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;

    // T4: illegal symbols dropped
    chk("t4_err_before", int'(err), 0);
    load_table();
    for (int i = 0; i < 7; i++) send_sym(seq4[i], i == 6);
    wait_frame();
    chk("t4_err_after", int'(err), 1);

    // T5: reset mid-frame
    load_table();
    send_sym(5, 0);
    @(negedge clk);
    chk("t5_cnt5_valid", int'(out_valid), 0);
    chk("t5_cnt5_ready", int'(sym_ready), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    sym_valid = 1'b1; sym_data = 8'd1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_bits.delete();
    model_total = 0;
    @(negedge clk);
    chk("t5_out_valid", int'(out_valid), 0);
    chk("t5_sym_ready", int'(sym_ready), 0);
    chk("t5_err_cleared", int'(err), 0);
    chk("t5_bit_count", int'(bit_count), 0);
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_ignored_ready", int'(sym_ready), 0);
      chk("t5_ignored_valid", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    sym_valid = 1'b0;
    load_table();
    send_sym(3, 0);
    send_sym(6, 1);
    wait_frame();

    chk("final_bytes_left", exp_bytes.size(), 0);
    chk("final_counts_left", exp_counts.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
